// File: rtl/rspi_ram_responder_pkg.sv
// Shared opcodes and FSM state encoding for the rspi RAM responder.
package rspi_pkg;

    localparam logic [7:0] RSPI_OP_READ  = 8'h03;
    localparam logic [7:0] RSPI_OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_WAIT_CE,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } rspi_state_e;

endpackage

// File: rtl/rspi_ram_responder_if.sv
// SPI pins plus the req/ack memory port of the rspi RAM responder.
interface rspi_ram_responder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_ce_n;
    logic              spi_miso;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              overrun;

    modport slave (
        input  spi_clk, spi_mosi, spi_ce_n, mem_ack, mem_rdata,
        output spi_miso, mem_req, mem_we, mem_addr, mem_wdata, overrun
    );

    modport master (
        output spi_clk, spi_mosi, spi_ce_n, mem_ack, mem_rdata,
        input  spi_miso, mem_req, mem_we, mem_addr, mem_wdata, overrun
    );
endinterface

// File: rtl/rspi_ram_responder_sync_edge.sv
// Two-flop synchroniser with a third flop for rise/fall pulse generation.
module rspi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    // Synchronise the async pin and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/rspi_ram_responder.sv
// SPI mode-0 serial-SRAM style target: READ/WRITE frames onto a req/ack byte port.
module rspi_ram_responder
    import rspi_pkg::*;
#(
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned ADDR_W     = 16,
    parameter logic        IDLE_MISO  = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    rspi_ram_responder_if.slave bus
);
    logic sck_level, sck_rise, sck_fall;
    logic mosi, mosi_rise, mosi_fall;
    logic ce_level, ce_rise, ce_fall;
    logic unused_edges;

    assign unused_edges = ^{sck_level, mosi_rise, mosi_fall, ce_rise};

    rspi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .din(bus.spi_clk),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );
    rspi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(bus.spi_mosi),
        .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
    );
    rspi_sync_edge #(.RST_VAL(1'b1)) u_sync_ce (
        .clk(clk), .rst(rst), .din(bus.spi_ce_n),
        .level(ce_level), .rise(ce_rise), .fall(ce_fall)
    );

    rspi_state_e       state;
    logic [7:0]        rx_sh, tx_sh, pf_data, pf_byte, rx_byte;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] addr, addr_shift, fetch_addr;
    logic              rd_op, pf_valid, fetch_pend, drop_ack;
    logic              mem_free, ack_kept, pf_ready, last_addr_byte;

    // Handshake status, prefetch availability and next shift values.
    always_comb begin
        mem_free       = !bus.mem_req || bus.mem_ack;
        ack_kept       = bus.mem_ack && !drop_ack && !bus.mem_we;
        pf_ready       = pf_valid || ack_kept;
        pf_byte        = pf_valid ? pf_data : bus.mem_rdata;
        rx_byte        = {rx_sh[6:0], mosi};
        addr_shift     = {addr[ADDR_W-2:0], mosi};
        last_addr_byte = (byte_cnt == 2'(ADDR_BYTES - 1));
        // A byte that missed its slot and was never issued is skipped, so the
        // next fetch stays aligned with the byte stream on miso.
        fetch_addr     = (!pf_ready && fetch_pend) ? addr + ADDR_W'(1) : addr;
    end

    // Frame FSM, shifters, address counter and memory request holder.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_WAIT_CE;
            rx_sh         <= '0;
            tx_sh         <= '0;
            pf_data       <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            addr          <= '0;
            rd_op         <= 1'b0;
            pf_valid      <= 1'b0;
            fetch_pend    <= 1'b0;
            drop_ack      <= 1'b0;
            bus.spi_miso  <= IDLE_MISO;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.overrun   <= 1'b0;
        end else begin
            if (bus.mem_ack) begin
                bus.mem_req <= 1'b0;
                drop_ack    <= 1'b0;
            end
            if (state == ST_READ && ack_kept) begin
                pf_data  <= bus.mem_rdata;
                pf_valid <= 1'b1;
            end
            if (state == ST_READ && fetch_pend && mem_free) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= addr;
                addr         <= addr + ADDR_W'(1);
                fetch_pend   <= 1'b0;
            end
            case (state)
                ST_WAIT_CE: begin
                    // bit_cnt doubles as a settle counter so the reset value of
                    // the ce_n synchroniser is never mistaken for a real high.
                    if (bit_cnt != 3'd2) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (ce_level) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end
                end
                ST_IDLE: begin
                    if (ce_fall) begin
                        state       <= ST_CMD;
                        bit_cnt     <= '0;
                        byte_cnt    <= '0;
                        addr        <= '0;
                        bus.overrun <= 1'b0;
                    end
                end
                default: begin
                    if (ce_level) begin
                        state        <= ST_IDLE;
                        bit_cnt      <= '0;
                        bus.spi_miso <= IDLE_MISO;
                        fetch_pend   <= 1'b0;
                        pf_valid     <= 1'b0;
                        if (bus.mem_req && !bus.mem_ack) drop_ack <= 1'b1;
                    end else begin
                        case (state)
                            ST_CMD: begin
                                if (sck_rise) begin
                                    rx_sh   <= rx_byte;
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        byte_cnt <= '0;
                                        if (rx_byte == RSPI_OP_READ) begin
                                            state <= ST_ADDR;
                                            rd_op <= 1'b1;
                                        end else if (rx_byte == RSPI_OP_WRITE) begin
                                            state <= ST_ADDR;
                                            rd_op <= 1'b0;
                                        end else begin
                                            state <= ST_IGNORE;
                                        end
                                    end
                                end
                            end
                            ST_ADDR: begin
                                if (sck_rise) begin
                                    addr    <= addr_shift;
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        byte_cnt <= byte_cnt + 2'd1;
                                        if (last_addr_byte) begin
                                            if (rd_op) begin
                                                state <= ST_READ;
                                                if (mem_free) begin
                                                    bus.mem_req  <= 1'b1;
                                                    bus.mem_we   <= 1'b0;
                                                    bus.mem_addr <= addr_shift;
                                                    addr         <= addr_shift + ADDR_W'(1);
                                                    fetch_pend   <= 1'b0;
                                                end else begin
                                                    fetch_pend   <= 1'b1;
                                                end
                                            end else begin
                                                state <= ST_WRITE;
                                            end
                                        end
                                    end
                                end
                            end
                            ST_READ: begin
                                if (sck_fall) begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd0) begin
                                        if (pf_ready) begin
                                            bus.spi_miso <= pf_byte[7];
                                            tx_sh        <= {pf_byte[6:0], 1'b0};
                                        end else begin
                                            bus.spi_miso <= 1'b1;
                                            tx_sh        <= 8'hFE;
                                            bus.overrun  <= 1'b1;
                                            if (bus.mem_req && !bus.mem_ack) drop_ack <= 1'b1;
                                        end
                                        pf_valid <= 1'b0;
                                        if (mem_free) begin
                                            bus.mem_req  <= 1'b1;
                                            bus.mem_we   <= 1'b0;
                                            bus.mem_addr <= fetch_addr;
                                            addr         <= fetch_addr + ADDR_W'(1);
                                            fetch_pend   <= 1'b0;
                                        end else begin
                                            addr         <= fetch_addr;
                                            fetch_pend   <= 1'b1;
                                        end
                                    end else begin
                                        bus.spi_miso <= tx_sh[7];
                                        tx_sh        <= {tx_sh[6:0], 1'b0};
                                    end
                                end
                            end
                            ST_WRITE: begin
                                if (sck_rise) begin
                                    rx_sh   <= rx_byte;
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        if (mem_free) begin
                                            bus.mem_req   <= 1'b1;
                                            bus.mem_we    <= 1'b1;
                                            bus.mem_addr  <= addr;
                                            bus.mem_wdata <= rx_byte;
                                            addr          <= addr + ADDR_W'(1);
                                        end else begin
                                            bus.overrun   <= 1'b1;
                                        end
                                    end
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
